// File: rtl/digit_scan_mux_pkg.sv
// Shared types, constants and blanking helpers for the multiplexed 4-digit display.
package digit_scan_mux_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [VALUE_W-1:0]    value;
    logic [NUM_DIGITS-1:0] blank;
    logic                  lz;
  } disp_cfg_t;

  // Power-up display: everything dark until the first load lands.
  localparam disp_cfg_t DISP_RESET = '{value: '0, blank: '1, lz: 1'b0};

  function automatic logic digit_blanked(input disp_cfg_t cfg, input digit_idx_t k);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= 32'(k)) && (cfg.value[j*NIBBLE_W +: NIBBLE_W] != '0)) upper_zero = 1'b0;
    end
    return cfg.blank[k] || (cfg.lz && (k != '0) && upper_zero);
  endfunction

  function automatic logic [NUM_DIGITS-1:0] anode_onehot_n(input digit_idx_t k);
    return ~(NUM_DIGITS'(1) << k);
  endfunction

endpackage

// File: rtl/digit_scan_mux_prescaler.sv
// Free-running 0..REFRESH_DIV-1 counter; strobes mark the first and last cycle of a slot.
module refresh_prescaler #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_zero_c,
  output logic o_term_c
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (o_term_c) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);
  assign o_term_c = (r_count == TERM);

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed 4-digit scanner with shadow/display double buffering and ghost guard.
module digit_scan_mux
  import digit_scan_mux_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [VALUE_W-1:0]    i_value,
  input  logic [NUM_DIGITS-1:0] i_blank,
  input  logic                  i_lz_en,
  output logic                  o_ready,
  output logic [NIBBLE_W-1:0]   o_digit_c,
  output logic [NUM_DIGITS-1:0] o_anode_c,
  output digit_idx_t            o_digit_sel,
  output logic                  o_frame_tick
);

  logic       w_zero;
  logic       w_term;
  logic       w_wrap;
  logic       w_accept;
  logic       w_blank;

  digit_idx_t r_idx;
  disp_cfg_t  r_disp;
  disp_cfg_t  r_shadow;
  logic       r_ready;
  logic       r_frame_tick;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .o_zero_c (w_zero),
    .o_term_c (w_term)
  );

  assign w_wrap   = w_term && (r_idx == LAST_DIGIT);
  assign w_accept = i_load && r_ready;

  // Digit index advances once per slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx <= '0;
    end else if (w_term) begin
      r_idx <= r_idx + digit_idx_t'(1);
    end
  end

  // Loads park in the shadow; display only swaps at a frame wrap so a frame never tears.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_disp   <= DISP_RESET;
      r_shadow <= '0;
      r_ready  <= 1'b1;
    end else if (w_accept) begin
      r_shadow <= {i_value, i_blank, i_lz_en};
      r_ready  <= 1'b0;
    end else if (w_wrap && !r_ready) begin
      r_disp  <= r_shadow;
      r_ready <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_wrap;
    end
  end

  // Outputs decode registered state only; the guard darkens the first cycle of each slot.
  assign w_blank      = digit_blanked(r_disp, r_idx);
  assign o_ready      = r_ready;
  assign o_digit_sel  = r_idx;
  assign o_frame_tick = r_frame_tick;
  assign o_digit_c    = r_disp.value[{r_idx, 2'b00} +: NIBBLE_W];
  assign o_anode_c    = (w_zero || w_blank) ? ANODE_OFF : anode_onehot_n(r_idx);

endmodule
